// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the punto-banco dealer control block:
// state encoding, card rank constants and the rank-to-point mapping.
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_P1     = 4'd1,
        S_D1     = 4'd2,
        S_P2     = 4'd3,
        S_D2     = 4'd4,
        S_EVAL   = 4'd5,
        S_P3     = 4'd6,
        S_BDEC   = 4'd7,
        S_D3     = 4'd8,
        S_RESULT = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    // Ranks 1..9 count face value; 10, J, Q, K count zero.
    localparam logic [3:0] RANK_ACE  = 4'd1;
    localparam logic [3:0] RANK_NINE = 4'd9;

    // Banker draws unconditionally on these two-card totals.
    localparam logic [3:0] BANKER_ALWAYS_MAX = 4'd2;

    // Point value of a card rank; 0 (no card) and out-of-range codes count zero.
    function automatic logic [3:0] card_point(input logic [3:0] rank);
        if (rank >= RANK_ACE && rank <= RANK_NINE)
            return rank;
        return 4'd0;
    endfunction

endpackage

// File: rtl/baccarat_dealer_fsm_if.sv
// Card datapath <-> dealer control bundle. The dealer (master) drives the
// card-load enables and the win lights; the datapath (slave) returns scores
// and the player's third-card rank.
interface baccarat_dealer_fsm_if;

    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light
    );

endinterface

// File: rtl/banker_draw_rule.sv
// Banker third-card rule, evaluated after the player has drawn a third card.
// Purely combinational: banker two-card total and player third-card rank in,
// draw decision out.
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] pt;

    assign pt = card_point(pcard3);

    // Decide banker draw from banker total and the player's third-card point.
    always_comb begin
        draw = 1'b0;
        if (dscore <= BANKER_ALWAYS_MAX) begin
            draw = 1'b1;
        end else begin
            case (dscore)
                4'd3:    draw = (pt != 4'd8);
                4'd4:    draw = (pt >= 4'd2) && (pt <= 4'd7);
                4'd5:    draw = (pt >= 4'd4) && (pt <= 4'd7);
                4'd6:    draw = (pt >= 4'd6) && (pt <= 4'd7);
                default: draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_dealer_fsm.sv
// Dealer control FSM: sequences the four-card deal, applies the punto-banco
// drawing rules for third cards and lights the winner(s). Loads and lights
// are registered so each is a clean, glitch-free Moore output.
module baccarat_dealer_fsm
    import baccarat_pkg::*;
#(
    parameter logic [3:0] NATURAL_MIN  = 4'd8,
    parameter logic [3:0] PLAYER_STAND = 4'd6
) (
    input  logic                          slow_clock,
    input  logic                          resetb,
    baccarat_dealer_fsm_if.master         bus
);

    state_t state;
    logic   banker_draw;

    banker_draw_rule u_banker_draw_rule (
        .dscore (bus.dscore),
        .pcard3 (bus.pcard3),
        .draw   (banker_draw)
    );

    // State register with load enables and lights registered alongside it.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state                <= S_RESET;
            bus.load_pcard1      <= 1'b0;
            bus.load_pcard2      <= 1'b0;
            bus.load_pcard3      <= 1'b0;
            bus.load_dcard1      <= 1'b0;
            bus.load_dcard2      <= 1'b0;
            bus.load_dcard3      <= 1'b0;
            bus.player_win_light <= 1'b0;
            bus.dealer_win_light <= 1'b0;
        end else begin
            // NOTE: every load and light defaults low each edge, so a pulse
            // lasts exactly one cycle and only S_DONE can keep a light lit.
            bus.load_pcard1      <= 1'b0;
            bus.load_pcard2      <= 1'b0;
            bus.load_pcard3      <= 1'b0;
            bus.load_dcard1      <= 1'b0;
            bus.load_dcard2      <= 1'b0;
            bus.load_dcard3      <= 1'b0;
            bus.player_win_light <= 1'b0;
            bus.dealer_win_light <= 1'b0;

            case (state)
                S_RESET: begin
                    state           <= S_P1;
                    bus.load_pcard1 <= 1'b1;
                end
                S_P1: begin
                    state           <= S_D1;
                    bus.load_dcard1 <= 1'b1;
                end
                S_D1: begin
                    state           <= S_P2;
                    bus.load_pcard2 <= 1'b1;
                end
                S_P2: begin
                    state           <= S_D2;
                    bus.load_dcard2 <= 1'b1;
                end
                S_D2: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    if (bus.pscore >= NATURAL_MIN || bus.dscore >= NATURAL_MIN) begin
                        state <= S_RESULT;
                    end else if (bus.pscore < PLAYER_STAND) begin
                        state           <= S_P3;
                        bus.load_pcard3 <= 1'b1;
                    end else if (bus.dscore <= 4'd5) begin
                        state           <= S_D3;
                        bus.load_dcard3 <= 1'b1;
                    end else begin
                        state <= S_RESULT;
                    end
                end
                S_P3: begin
                    state <= S_BDEC;
                end
                S_BDEC: begin
                    if (banker_draw) begin
                        state           <= S_D3;
                        bus.load_dcard3 <= 1'b1;
                    end else begin
                        state <= S_RESULT;
                    end
                end
                S_D3: begin
                    state <= S_RESULT;
                end
                S_RESULT: begin
                    state                <= S_DONE;
                    bus.player_win_light <= (bus.pscore >= bus.dscore);
                    bus.dealer_win_light <= (bus.dscore >= bus.pscore);
                end
                S_DONE: begin
                    state                <= S_DONE;
                    bus.player_win_light <= bus.player_win_light;
                    bus.dealer_win_light <= bus.dealer_win_light;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// Directed bench for the dealer FSM: drives scores/pcard3 as the datapath
// would and checks the six loads and two lights after every edge.
module tb_baccarat_dealer_fsm;

    logic slow_clock;
    logic resetb;
    int   checks;
    int   errors;

    baccarat_dealer_fsm_if bus ();

    baccarat_dealer_fsm dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus.master)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // Expected output codes: {p1,d1,p2,d2,p3,d3,player,dealer}
    localparam logic [7:0] O_IDLE = 8'b000000_00;
    localparam logic [7:0] O_P1   = 8'b100000_00;
    localparam logic [7:0] O_D1   = 8'b010000_00;
    localparam logic [7:0] O_P2   = 8'b001000_00;
    localparam logic [7:0] O_D2   = 8'b000100_00;
    localparam logic [7:0] O_P3   = 8'b000010_00;
    localparam logic [7:0] O_D3   = 8'b000001_00;
    localparam logic [7:0] O_WINP = 8'b000000_10;
    localparam logic [7:0] O_WIND = 8'b000000_01;
    localparam logic [7:0] O_TIE  = 8'b000000_11;

    function automatic logic [7:0] observe();
        return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
                bus.load_dcard2, bus.load_pcard3, bus.load_dcard3,
                bus.player_win_light, bus.dealer_win_light};
    endfunction

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge slow_clock);
        #1;
        check(tag, observe(), exp);
    endtask

    task automatic set_scores(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c3);
        bus.pscore = p;
        bus.dscore = d;
        bus.pcard3 = c3;
    endtask

    // Assert reset, check outputs, release at a falling edge so the next
    // rising edge is e1; then walk the four-card deal through e5 (S_EVAL).
    task automatic new_hand(input string tag, input logic [3:0] p, input logic [3:0] d,
                            input logic [3:0] c3);
        @(negedge slow_clock);
        resetb = 1'b0;
        #1;
        check({tag, "_reset"}, observe(), O_IDLE);
        set_scores(p, d, c3);
        @(negedge slow_clock);
        resetb = 1'b1;
        step({tag, "_e1"}, O_P1);
        step({tag, "_e2"}, O_D1);
        step({tag, "_e3"}, O_P2);
        step({tag, "_e4"}, O_D2);
        step({tag, "_e5"}, O_IDLE);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetb = 1'b0;
        set_scores(4'd0, 4'd0, 4'd0);
        #12;
        check("por_reset", observe(), O_IDLE);

        // 1: player natural 8 vs 3 -> player wins at e7, held after.
        new_hand("nat", 4'd8, 4'd3, 4'd0);
        step("nat_e6", O_IDLE);
        step("nat_e7", O_WINP);
        set_scores(4'd0, 4'd9, 4'd0);
        step("nat_hold", O_WINP);

        // 1b: dealer natural 9 vs 5 -> dealer wins at e7.
        new_hand("dnat", 4'd5, 4'd9, 4'd0);
        step("dnat_e6", O_IDLE);
        step("dnat_e7", O_WIND);

        // 2: player draws (4), banker 6 with pt 7 draws; final 9 vs 2.
        new_hand("both", 4'd4, 4'd6, 4'd7);
        step("both_e6", O_P3);
        step("both_e7", O_IDLE);
        step("both_e8", O_D3);
        set_scores(4'd9, 4'd2, 4'd7);
        step("both_e9", O_IDLE);
        step("both_e10", O_WINP);

        // 3: player draws, banker 3 with pt 8 stands; final 0 vs 3.
        new_hand("bstd", 4'd2, 4'd3, 4'd8);
        step("bstd_e6", O_P3);
        step("bstd_e7", O_IDLE);
        step("bstd_e8", O_IDLE);
        set_scores(4'd0, 4'd3, 4'd8);
        step("bstd_e9", O_WIND);

        // 4: player stands on 7, dealer 4 draws; final 7 vs 7 tie.
        new_hand("pstd", 4'd7, 4'd4, 4'd0);
        step("pstd_e6", O_D3);
        set_scores(4'd7, 4'd7, 4'd0);
        step("pstd_e7", O_IDLE);
        step("pstd_e8", O_TIE);

        // Boundary: 6 vs 6 both stand -> tie at e7.
        new_hand("six", 4'd6, 4'd6, 4'd0);
        step("six_e6", O_IDLE);
        step("six_e7", O_TIE);

        // 5a: banker 4, player third card Q (point 0) -> banker stands.
        new_hand("q", 4'd3, 4'd4, 4'd12);
        step("q_e6", O_P3);
        step("q_e7", O_IDLE);
        step("q_e8", O_IDLE);
        step("q_e9", O_WIND);

        // 5b: same totals, third card 2 -> banker draws; 3 vs 4 final.
        new_hand("two", 4'd3, 4'd4, 4'd2);
        step("two_e6", O_P3);
        step("two_e7", O_IDLE);
        step("two_e8", O_D3);
        step("two_e9", O_IDLE);
        step("two_e10", O_WIND);

        // 6: reset mid-cycle in S_P3 clears outputs at once; hand restarts.
        new_hand("abort", 4'd1, 4'd1, 4'd5);
        step("abort_e6", O_P3);
        #2;
        resetb = 1'b0;
        #1;
        check("abort_async", observe(), O_IDLE);
        set_scores(4'd9, 4'd9, 4'd0);
        @(negedge slow_clock);
        resetb = 1'b1;
        step("rst_e1", O_P1);
        step("rst_e2", O_D1);
        step("rst_e3", O_P2);
        step("rst_e4", O_D2);
        step("rst_e5", O_IDLE);
        step("rst_e6", O_IDLE);
        step("rst_e7", O_TIE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
